neurram_spi_input_packer: RTL and testbench

Upstream feeder for `neurram_spi_control`. It accepts whole two-lane SPI input vectors of SPI_LENGTH bits per lane and packs each into SPI_LENGTH/16 interleaved 32-bit words. It writes those words into the controller's pipe-in FIFO under full-flag backpressure. Once a programmed number of vectors is loaded, it fires `spi_trigger` and tracks `spi_idle` to report completion.

---
 rtl/neurram_pkg.sv | 22 ++
 rtl/neurram_spi_input_packer_if.sv | 31 +++
 rtl/neurram_lane_interleave.sv | 29 ++
 rtl/neurram_spi_input_packer.sv | 205 ++++++++++++++++++++
 tb/tb_neurram_spi_input_packer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neurram_pkg.sv
// Shared definitions for the NeuRRAM SPI input packer: FSM state encoding,
// words-per-vector helper and default start timeout.
package neurram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_PACK       = 3'd2,
    ST_ARM        = 3'd3,
    ST_WAIT_START = 3'd4,
    ST_WAIT_END   = 3'd5
  } packer_state_e;

  // Cycles allowed for spi_idle to fall after a trigger.
  localparam int DEFAULT_START_TIMEOUT = 8;

  // Each 32-bit FIFO word carries 16 bits from each of the two lanes.
  function automatic int WORDS_PER_VECTOR(input int spi_length);
    return spi_length / 16;
  endfunction

endpackage

// File: rtl/neurram_spi_input_packer_if.sv
// Handshake and bus bundle between the packer and its environment.
// The slave modport is the packer itself; master is the surrounding logic
// (vector source, controller FIFO and controller status).
interface neurram_spi_input_packer_if #(
  parameter int SPI_LENGTH = 256
);
  logic                  start;
  logic [3:0]            num_vectors;
  logic                  vec_valid;
  logic                  vec_ready;
  logic [SPI_LENGTH-1:0] vec_lane0;
  logic [SPI_LENGTH-1:0] vec_lane1;
  logic [31:0]           fifo_din;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic                  spi_idle;
  logic                  spi_trigger;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, num_vectors, vec_valid, vec_lane0, vec_lane1, fifo_full, spi_idle,
    output vec_ready, fifo_din, fifo_wr_en, spi_trigger, busy, done, err
  );

  modport master (
    output start, num_vectors, vec_valid, vec_lane0, vec_lane1, fifo_full, spi_idle,
    input  vec_ready, fifo_din, fifo_wr_en, spi_trigger, busy, done, err
  );
endinterface

// File: rtl/neurram_lane_interleave.sv
// Builds one 32-bit pipe-in word from two lanes: bit 2i comes from lane0 and
// bit 2i+1 from lane1, both taken from bit position word_idx*16+i.
// This is the inverse of the controller's pipe-in bit mapping.
module neurram_lane_interleave #(
  parameter int SPI_LENGTH = 256,
  parameter int IDX_W      = 4
) (
  input  logic [SPI_LENGTH-1:0] i_lane0,
  input  logic [SPI_LENGTH-1:0] i_lane1,
  input  logic [IDX_W-1:0]      i_word_idx,
  output logic [31:0]           o_word
);

  logic [15:0] w_seg0;
  logic [15:0] w_seg1;

  assign w_seg0 = i_lane0[{i_word_idx, 4'd0} +: 16];
  assign w_seg1 = i_lane1[{i_word_idx, 4'd0} +: 16];

  // Interleave the two 16-bit lane segments bit by bit.
  always_comb begin
    o_word = 32'd0;
    for (int i = 0; i < 16; i++) begin
      o_word[2*i]   = w_seg0[i];
      o_word[2*i+1] = w_seg1[i];
    end
  end

endmodule

// File: rtl/neurram_spi_input_packer.sv
// Loads num_vectors two-lane SPI vectors into the controller pipe-in FIFO as
// interleaved 32-bit words, then triggers the controller and watches spi_idle
// for start (with timeout) and completion.
module neurram_spi_input_packer
  import neurram_pkg::*;
#(
  parameter int SPI_LENGTH    = 256,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  neurram_spi_input_packer_if.slave   bus
);

  localparam int WPV   = WORDS_PER_VECTOR(SPI_LENGTH);
  localparam int IDX_W = (WPV > 1) ? $clog2(WPV) : 1;
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);

  packer_state_e         r_state;
  packer_state_e         w_next_state;

  logic [3:0]            r_num;
  logic [3:0]            r_vcnt;
  logic [IDX_W-1:0]      r_k;
  logic [SPI_LENGTH-1:0] r_lane0;
  logic [SPI_LENGTH-1:0] r_lane1;
  logic [TO_W-1:0]       r_to_cnt;
  logic [31:0]           r_fifo_din;
  logic                  r_vec_ready;
  logic                  r_busy;
  logic                  r_trigger;
  logic                  r_done;
  logic                  r_err;

  logic                  w_handshake;
  logic                  w_write;
  logic                  w_last_word;
  logic [3:0]            w_vcnt_inc;
  logic [IDX_W-1:0]      w_k_next;
  logic                  w_to_expired;
  logic                  w_trigger_set;
  logic                  w_done_set;
  logic                  w_err_set;
  logic [SPI_LENGTH-1:0] w_il_lane0;
  logic [SPI_LENGTH-1:0] w_il_lane1;
  logic [IDX_W-1:0]      w_il_idx;
  logic [31:0]           w_word;

  assign w_handshake  = (r_state == ST_LOAD) && bus.vec_valid;
  assign w_write      = (r_state == ST_PACK) && !bus.fifo_full;
  assign w_last_word  = (r_k == IDX_W'(WPV - 1));
  assign w_vcnt_inc   = r_vcnt + 4'd1;
  assign w_k_next     = w_last_word ? {IDX_W{1'b0}} : (r_k + IDX_W'(1));
  assign w_to_expired = (r_to_cnt == TO_W'(START_TIMEOUT - 1));

  // The word register is preloaded with the word that will be shown next:
  // word 0 of the incoming vector on a handshake, word k+1 of the held vector
  // on a write. fifo_din therefore stays stable across a stall.
  always_comb begin
    w_il_lane0 = r_lane0;
    w_il_lane1 = r_lane1;
    w_il_idx   = w_k_next;
    if (r_state == ST_LOAD) begin
      w_il_lane0 = bus.vec_lane0;
      w_il_lane1 = bus.vec_lane1;
      w_il_idx   = {IDX_W{1'b0}};
    end else begin
      w_il_lane0 = r_lane0;
      w_il_lane1 = r_lane1;
      w_il_idx   = w_k_next;
    end
  end

  neurram_lane_interleave #(
    .SPI_LENGTH (SPI_LENGTH),
    .IDX_W      (IDX_W)
  ) u_interleave (
    .i_lane0    (w_il_lane0),
    .i_lane1    (w_il_lane1),
    .i_word_idx (w_il_idx),
    .o_word     (w_word)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic and the one-cycle event strobes.
  always_comb begin
    w_next_state  = r_state;
    w_trigger_set = 1'b0;
    w_done_set    = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && (bus.num_vectors != 4'd0)) w_next_state = ST_LOAD;
        else                                        w_next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_handshake) w_next_state = ST_PACK;
        else             w_next_state = ST_LOAD;
      end
      ST_PACK: begin
        if (w_write && w_last_word) begin
          if (w_vcnt_inc < r_num) w_next_state = ST_LOAD;
          else                    w_next_state = ST_ARM;
        end else begin
          w_next_state = ST_PACK;
        end
      end
      ST_ARM: begin
        if (bus.spi_idle) begin
          w_next_state  = ST_WAIT_START;
          w_trigger_set = 1'b1;
        end else begin
          w_next_state = ST_ARM;
        end
      end
      ST_WAIT_START: begin
        if (!bus.spi_idle) begin
          w_next_state = ST_WAIT_END;
        end else if (w_to_expired) begin
          w_next_state = ST_IDLE;
          w_err_set    = 1'b1;
        end else begin
          w_next_state = ST_WAIT_START;
        end
      end
      ST_WAIT_END: begin
        if (bus.spi_idle) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end else begin
          w_next_state = ST_WAIT_END;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: counters, holding registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= 4'd0;
      r_vcnt      <= 4'd0;
      r_k         <= {IDX_W{1'b0}};
      r_lane0     <= {SPI_LENGTH{1'b0}};
      r_lane1     <= {SPI_LENGTH{1'b0}};
      r_to_cnt    <= {TO_W{1'b0}};
      r_fifo_din  <= 32'd0;
      r_vec_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_trigger   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_vec_ready <= (w_next_state == ST_LOAD);
      r_busy      <= (w_next_state != ST_IDLE);
      r_trigger   <= w_trigger_set;
      r_done      <= w_done_set;
      r_err       <= w_err_set;

      if ((r_state == ST_IDLE) && (w_next_state == ST_LOAD)) begin
        r_num  <= bus.num_vectors;
        r_vcnt <= 4'd0;
        r_k    <= {IDX_W{1'b0}};
      end

      if (w_handshake) begin
        r_lane0    <= bus.vec_lane0;
        r_lane1    <= bus.vec_lane1;
        r_k        <= {IDX_W{1'b0}};
        r_fifo_din <= w_word;
      end

      if (w_write) begin
        r_k        <= w_k_next;
        r_fifo_din <= w_word;
        if (w_last_word) r_vcnt <= w_vcnt_inc;
      end

      if (w_trigger_set) begin
        r_to_cnt <= {TO_W{1'b0}};
      end else if (r_state == ST_WAIT_START) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  assign bus.vec_ready   = r_vec_ready;
  assign bus.fifo_din    = r_fifo_din;
  assign bus.fifo_wr_en  = (r_state == ST_PACK) && !bus.fifo_full;
  assign bus.spi_trigger = r_trigger;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_neurram_spi_input_packer.sv
// Bench for the SPI input packer: random vectors, a stream model built from
// the interleave rule, a small controller model for spi_idle, and a monitor
// recording FIFO writes and event pulses with cycle stamps.
module tb_neurram_spi_input_packer;

  localparam int L   = 256;
  localparam int WPV = L / 16;
  localparam int TO  = 8;
  localparam int CTL_BUSY = 5;

  logic clk = 1'b0;
  logic rst;

  neurram_spi_input_packer_if #(.SPI_LENGTH(L)) bus();

  neurram_spi_input_packer #(.SPI_LENGTH(L), .START_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc = -1;
  bit ctl_stuck = 1'b0;

  logic [31:0] q_din[$];
  int          q_wcyc[$];
  int          q_trig[$];
  int          q_done[$];
  int          q_err[$];

  logic [L-1:0] tv_l0[16];
  logic [L-1:0] tv_l1[16];

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: records writes and pulses; done and err must never coincide.
  initial forever begin
    @(negedge clk);
    if (bus.fifo_wr_en) begin
      q_din.push_back(bus.fifo_din);
      q_wcyc.push_back(cyc);
    end
    if (bus.spi_trigger) q_trig.push_back(cyc);
    if (bus.done)        q_done.push_back(cyc);
    if (bus.err)         q_err.push_back(cyc);
    if (bus.done || bus.err) begin
      total++;
      if (bus.done && bus.err) begin
        bad++;
        $display("FAIL done_err_exclusive got done=%b err=%b want not both", bus.done, bus.err);
      end
    end
  end

  // Controller model: spi_idle drops 2 cycles after a trigger, stays low
  // CTL_BUSY cycles, then returns high. Stuck mode never leaves idle.
  initial begin
    bus.spi_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.spi_trigger && !ctl_stuck) begin
        @(posedge clk);
        @(posedge clk);
        #1 bus.spi_idle = 1'b0;
        repeat (CTL_BUSY) @(posedge clk);
        #1 bus.spi_idle = 1'b1;
      end
    end
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference: interleaved bitstream of vector v, word k.
  function automatic logic [31:0] exp_word(input int v, input int k);
    logic [2*L-1:0] s;
    for (int j = 0; j < L; j++) begin
      s[2*j]   = tv_l0[v][j];
      s[2*j+1] = tv_l1[v][j];
    end
    return s[32*k +: 32];
  endfunction

  task automatic rand_vecs(input int n);
    for (int v = 0; v < n; v++)
      for (int j = 0; j < L/32; j++) begin
        tv_l0[v][32*j +: 32] = $urandom();
        tv_l1[v][32*j +: 32] = $urandom();
      end
  endtask

  task automatic clear_sb();
    q_din.delete(); q_wcyc.delete(); q_trig.delete(); q_done.delete(); q_err.delete();
  endtask

  // Entered and left at posedge+1.
  task automatic pulse_start(input logic [3:0] nv);
    bus.start = 1'b1;
    bus.num_vectors = nv;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    bit got;
    int w;
    for (int v = 0; v < n; v++) begin
      bus.vec_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.vec_lane0 = tv_l0[v];
      bus.vec_lane1 = tv_l1[v];
      bus.vec_valid = 1'b1;
      got = 1'b0;
      w = 0;
      while (!got && w < 300) begin
        @(negedge clk);
        got = bus.vec_ready;
        if (!got) begin @(posedge clk); #1; w++; end
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL feed_timeout got vec_ready=0 want 1 (vector %0d)", v);
        bus.vec_valid = 1'b0;
        return;
      end
      hs_cyc = cyc;
      @(posedge clk); #1;
    end
    bus.vec_valid = 1'b0;
  endtask

  task automatic wait_end(input int limit, output bit ok);
    int n = 0;
    while (q_done.size() == 0 && q_err.size() == 0 && n < limit) begin
      @(posedge clk); #1; n++;
    end
    ok = (q_done.size() != 0) || (q_err.size() != 0);
  endtask

  task automatic test_reset();
    logic [31:0] o[7];
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    o[0] = 32'(bus.vec_ready); o[1] = bus.fifo_din; o[2] = 32'(bus.fifo_wr_en);
    o[3] = 32'(bus.spi_trigger); o[4] = 32'(bus.busy); o[5] = 32'(bus.done); o[6] = 32'(bus.err);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (o[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset_out%0d got=%h want=0", i, o[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok;
    int t;
    tv_l0[0] = {L{1'b1}};
    tv_l1[0] = {L{1'b0}};
    clear_sb();
    pulse_start(4'd1);
    feed(1, 0);
    wait_end(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_end got none want done"); end
    total++; if (q_din.size() != WPV) begin bad++; $display("FAIL single_count got=%0d want=%0d", q_din.size(), WPV); end
    for (int k = 0; k < q_din.size(); k++) begin
      total++;
      if (q_din[k] !== 32'h5555_5555) begin bad++; $display("FAIL single_word%0d got=%h want=55555555", k, q_din[k]); end
    end
    if (q_din.size() == WPV) begin
      total++;
      if (q_wcyc[0] != hs_cyc + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", q_wcyc[0], hs_cyc + 1); end
      total++;
      if (q_wcyc[WPV-1] != q_wcyc[0] + WPV - 1) begin bad++; $display("FAIL single_consecutive got=%0d want=%0d", q_wcyc[WPV-1] - q_wcyc[0], WPV - 1); end
      t = (q_trig.size() == 1) ? q_trig[0] : -1;
      total++;
      if (t != q_wcyc[WPV-1] + 2) begin bad++; $display("FAIL single_trigger got=%0d want=%0d (n=%0d)", t, q_wcyc[WPV-1] + 2, q_trig.size()); end
      total++;
      if (q_done.size() != 1 || q_done[0] != t + 3 + CTL_BUSY) begin
        bad++; $display("FAIL single_done got n=%0d want one at %0d", q_done.size(), t + 3 + CTL_BUSY);
      end
    end
    total++; if (q_err.size() != 0) begin bad++; $display("FAIL single_err got=%0d want=0", q_err.size()); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_corner();
    bit ok;
    logic [31:0] want;
    tv_l0[0] = {L{1'b0}}; tv_l0[0][0] = 1'b1;
    tv_l1[0] = {L{1'b0}}; tv_l1[0][L-1] = 1'b1;
    clear_sb();
    pulse_start(4'd1);
    feed(1, 0);
    wait_end(300, ok);
    total++; if (q_din.size() != WPV) begin bad++; $display("FAIL corner_count got=%0d want=%0d", q_din.size(), WPV); end
    for (int k = 0; k < q_din.size(); k++) begin
      want = (k == 0) ? 32'h0000_0001 : ((k == WPV - 1) ? 32'h8000_0000 : 32'h0000_0000);
      total++;
      if (q_din[k] !== want) begin bad++; $display("FAIL corner_word%0d got=%h want=%h", k, q_din[k], want); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    rand_vecs(1);
    clear_sb();
    pulse_start(4'd1);
    fork
      feed(1, 0);
      begin
        n = 0;
        while (q_din.size() < 7 && n < 300) begin @(posedge clk); #1; n++; end
        bus.fifo_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== exp_word(0, 7)) begin
            bad++; $display("FAIL stall_hold got wr=%b din=%h want wr=0 din=%h", bus.fifo_wr_en, bus.fifo_din, exp_word(0, 7));
          end
          @(posedge clk); #1;
        end
        bus.fifo_full = 1'b0;
      end
    join
    wait_end(300, ok);
    total++; if (q_din.size() != WPV) begin bad++; $display("FAIL stall_count got=%0d want=%0d", q_din.size(), WPV); end
    for (int k = 0; k < q_din.size(); k++) begin
      total++;
      if (q_din[k] !== exp_word(0, k)) begin bad++; $display("FAIL stall_word%0d got=%h want=%h", k, q_din[k], exp_word(0, k)); end
    end
    if (q_din.size() == WPV) begin
      total++;
      if (q_wcyc[7] - q_wcyc[6] != 6) begin bad++; $display("FAIL stall_gap got=%0d want=6", q_wcyc[7] - q_wcyc[6]); end
    end
  endtask

  task automatic test_multi();
    bit ok;
    int t;
    rand_vecs(3);
    clear_sb();
    pulse_start(4'd3);
    feed(3, 4);
    wait_end(600, ok);
    total++; if (q_din.size() != 3*WPV) begin bad++; $display("FAIL multi_count got=%0d want=%0d", q_din.size(), 3*WPV); end
    for (int k = 0; k < q_din.size(); k++) begin
      total++;
      if (q_din[k] !== exp_word(k / WPV, k % WPV)) begin
        bad++; $display("FAIL multi_word%0d got=%h want=%h", k, q_din[k], exp_word(k / WPV, k % WPV));
      end
    end
    if (q_din.size() == 3*WPV) begin
      t = (q_trig.size() == 1) ? q_trig[0] : -1;
      total++;
      if (t != q_wcyc[3*WPV-1] + 2) begin bad++; $display("FAIL multi_trigger got=%0d want=%0d (n=%0d)", t, q_wcyc[3*WPV-1] + 2, q_trig.size()); end
    end
    total++; if (q_done.size() != 1) begin bad++; $display("FAIL multi_done got=%0d want=1", q_done.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rand_vecs(2);
    clear_sb();
    pulse_start(4'd2);
    fork
      feed(2, 0);
      begin repeat (6) begin @(posedge clk); #1; end pulse_start(4'd5); end
    join
    wait_end(600, ok);
    total++; if (q_din.size() != 2*WPV) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", q_din.size(), 2*WPV); end
    for (int k = 0; k < q_din.size(); k++) begin
      total++;
      if (q_din[k] !== exp_word(k / WPV, k % WPV)) begin
        bad++; $display("FAIL b2b_word%0d got=%h want=%h", k, q_din[k], exp_word(k / WPV, k % WPV));
      end
    end
    if (q_din.size() == 2*WPV) begin
      total++;
      if (q_wcyc[WPV] - q_wcyc[WPV-1] != 2) begin bad++; $display("FAIL b2b_load_gap got=%0d want=2", q_wcyc[WPV] - q_wcyc[WPV-1]); end
    end
    total++; if (q_trig.size() != 1) begin bad++; $display("FAIL b2b_trigger got=%0d want=1", q_trig.size()); end
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.vec_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got busy=%b ready=%b want 0 0", bus.busy, bus.vec_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_zero();
    pulse_start(4'd0);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.vec_ready !== 1'b0) begin
        bad++; $display("FAIL zero_ignored got busy=%b ready=%b want 0 0", bus.busy, bus.vec_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t;
    rand_vecs(1);
    ctl_stuck = 1'b1;
    clear_sb();
    pulse_start(4'd1);
    feed(1, 0);
    wait_end(300, ok);
    t = (q_trig.size() == 1) ? q_trig[0] : -100;
    total++;
    if (q_err.size() != 1 || q_err[0] != t + TO) begin
      bad++; $display("FAIL timeout_err got n=%0d want one at %0d", q_err.size(), t + TO);
    end
    total++; if (q_done.size() != 0) begin bad++; $display("FAIL timeout_done got=%0d want=0", q_done.size()); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", bus.busy); end
    @(posedge clk); #1;
    ctl_stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [31:0] o[7];
    rand_vecs(1);
    clear_sb();
    pulse_start(4'd1);
    feed(1, 0);
    n = 0;
    while (q_din.size() < 9 && n < 300) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    o[0] = 32'(bus.vec_ready); o[1] = bus.fifo_din; o[2] = 32'(bus.fifo_wr_en);
    o[3] = 32'(bus.spi_trigger); o[4] = 32'(bus.busy); o[5] = 32'(bus.done); o[6] = 32'(bus.err);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (o[i] !== 32'd0) begin bad++; $display("FAIL midrst_out%0d got=%h want=0", i, o[i]); end
    end
    @(posedge clk); #1;
    clear_sb();
    pulse_start(4'd1);
    feed(1, 0);
    wait_end(300, ok);
    total++; if (q_din.size() != WPV) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", q_din.size(), WPV); end
    for (int k = 0; k < q_din.size(); k++) begin
      total++;
      if (q_din[k] !== exp_word(0, k)) begin bad++; $display("FAIL midrst_word%0d got=%h want=%h", k, q_din[k], exp_word(0, k)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_vectors = 4'd0;
    bus.vec_valid = 1'b0;
    bus.vec_lane0 = {L{1'b0}};
    bus.vec_lane1 = {L{1'b0}};
    bus.fifo_full = 1'b0;
    #1;
    test_reset();
    test_single();
    test_corner();
    test_stall();
    test_multi();
    test_back_to_back();
    test_ignore_zero();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
